// File: rtl/compositor_pkg.sv
// Shared colour type, fixed palette and state/region encodings for the layer compositor.
package compositor_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BLACK      = rgb_t'(24'h000000);
  localparam rgb_t SKY_RGB    = rgb_t'(24'h0000FF);
  localparam rgb_t STRATA_RGB [4] = '{rgb_t'(24'hFFA933), rgb_t'(24'hB5651D),
                                      rgb_t'(24'hB22222), rgb_t'(24'h800000)};

  typedef enum logic [1:0] {REG_OFF, REG_SKY, REG_DIRT} region_e;
  typedef enum logic {MAP_IDLE, MAP_CLEAR} map_state_e;

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel, layer, dig-map and VGA signals between the generators/game logic and the compositor.
interface layer_compositor_if #(
  parameter int N_LAYERS = 8,
  parameter int DIG_X_W  = 5,
  parameter int DIG_Y_W  = 5
);
  logic                    pix_valid;
  logic [9:0]              DrawX;
  logic [9:0]              DrawY;
  logic [N_LAYERS-1:0]     layer_hit;
  logic [24*N_LAYERS-1:0]  layer_color;
  logic [N_LAYERS-1:0]     layer_blink;
  logic                    frame_start;
  logic                    dig_we;
  logic [DIG_X_W-1:0]      dig_x;
  logic [DIG_Y_W-1:0]      dig_y;
  logic                    map_clear;
  logic                    map_busy;
  logic                    out_valid;
  logic [7:0]              VGA_R;
  logic [7:0]              VGA_G;
  logic [7:0]              VGA_B;

  modport master (
    output pix_valid, DrawX, DrawY, layer_hit, layer_color, layer_blink,
    output frame_start, dig_we, dig_x, dig_y, map_clear,
    input  map_busy, out_valid, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input  pix_valid, DrawX, DrawY, layer_hit, layer_color, layer_blink,
    input  frame_start, dig_we, dig_x, dig_y, map_clear,
    output map_busy, out_valid, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/layer_compositor_dig_map.sv
// Dig-map grid: single-cell write port, row-per-cycle clear sequencer, combinational read port.
module dig_map
  import compositor_pkg::*;
#(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24,
  parameter int X_W    = $clog2(GRID_W),
  parameter int Y_W    = $clog2(GRID_H)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [X_W-1:0] wr_x,
  input  logic [Y_W-1:0] wr_y,
  input  logic           clear,
  output logic           busy,
  input  logic [9:0]     rd_col,
  input  logic [9:0]     rd_row,
  output logic           dug
);

  map_state_e        state_q, state_d;
  logic [Y_W-1:0]    row_q, row_d;
  logic              wr_fire, clr_fire;
  logic [GRID_W-1:0] grid [GRID_H];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MAP_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // A clear request beats a same-cycle write; writes are dropped while clearing.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    wr_fire  = 1'b0;
    clr_fire = 1'b0;
    case (state_q)
      MAP_IDLE: begin
        if (clear) begin
          state_d = MAP_CLEAR;
          row_d   = '0;
        end else if (we && int'(wr_x) < GRID_W && int'(wr_y) < GRID_H) begin
          wr_fire = 1'b1;
        end
      end
      MAP_CLEAR: begin
        clr_fire = 1'b1;
        if (int'(row_q) == GRID_H - 1) state_d = MAP_IDLE;
        else                           row_d   = row_q + 1'b1;
      end
      default: state_d = MAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < GRID_H; r++) grid[r] <= '0;
    end else if (clr_fire) begin
      grid[row_q] <= '0;
    end else if (wr_fire) begin
      grid[wr_y][wr_x] <= 1'b1;
    end
  end

  assign busy = (state_q == MAP_CLEAR);

  // Bypass lets a pixel sampled on the same edge as the write see the new dug bit.
  always_comb begin
    dug = 1'b0;
    if (int'(rd_col) < GRID_W && int'(rd_row) < GRID_H) begin
      dug = grid[rd_row[Y_W-1:0]][rd_col[X_W-1:0]] |
            (wr_fire && wr_x == rd_col[X_W-1:0] && wr_y == rd_row[Y_W-1:0]);
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: prioritised blinking layers over sky/strata background with dig map.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int N_LAYERS    = 8,
  parameter int PLAYFIELD_W = 512,
  parameter int SKY_H       = 96,
  parameter int STRATUM_H   = 96,
  parameter int N_STRATA    = 4,
  parameter int CELL        = 16,
  parameter int FRAME_CNT_W = 6,
  parameter int BLINK_BIT   = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  layer_compositor_if.slave  bus
);

  localparam int GRID_W  = PLAYFIELD_W / CELL;
  localparam int GRID_H  = N_STRATA * STRATUM_H / CELL;
  localparam int CELL_SH = $clog2(CELL);
  localparam int S_W     = (N_STRATA > 1) ? $clog2(N_STRATA) : 1;

  function automatic logic [S_W-1:0] clamp_stratum(input logic [9:0] idx);
    if (idx >= 10'(N_STRATA - 1)) return S_W'(N_STRATA - 1);
    return S_W'(idx);
  endfunction

  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   blink_off;

  always_ff @(posedge Clk) begin
    if (!Reset_n)             frame_cnt <= '0;
    else if (bus.frame_start) frame_cnt <= frame_cnt + 1'b1;
  end

  assign blink_off = frame_cnt[BLINK_BIT];

  // ---- stage 1: region classification and dug lookup ----
  logic [9:0] ydiff, rd_col, rd_row;
  region_e    region_c;
  logic       dug_rd;

  assign ydiff  = bus.DrawY - 10'(SKY_H);
  assign rd_col = bus.DrawX >> CELL_SH;
  assign rd_row = ydiff >> CELL_SH;

  always_comb begin
    if (int'(bus.DrawX) >= PLAYFIELD_W) region_c = REG_OFF;
    else if (int'(bus.DrawY) < SKY_H)   region_c = REG_SKY;
    else                                region_c = REG_DIRT;
  end

  dig_map #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_dig_map (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .we     (bus.dig_we),
    .wr_x   (bus.dig_x),
    .wr_y   (bus.dig_y),
    .clear  (bus.map_clear),
    .busy   (bus.map_busy),
    .rd_col (rd_col),
    .rd_row (rd_row),
    .dug    (dug_rd)
  );

  logic                   vld_p1;
  logic [N_LAYERS-1:0]    hit_p1, blink_p1;
  logic [24*N_LAYERS-1:0] color_p1;
  region_e                region_p1;
  logic [S_W-1:0]         stratum_p1;
  logic                   dug_p1;

  always_ff @(posedge Clk) begin
    if (!Reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= bus.pix_valid;
  end

  always_ff @(posedge Clk) begin
    hit_p1     <= bus.layer_hit;
    blink_p1   <= bus.layer_blink;
    color_p1   <= bus.layer_color;
    region_p1  <= region_c;
    stratum_p1 <= clamp_stratum(ydiff / 10'(STRATUM_H));
    dug_p1     <= dug_rd && (region_c == REG_DIRT);
  end

  // ---- stage 2: layer priority and background select ----
  rgb_t pix_c;
  logic found;

  always_comb begin
    pix_c = BLACK;
    found = 1'b0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (!found && hit_p1[i] && !(blink_p1[i] && blink_off)) begin
        found = 1'b1;
        pix_c = rgb_t'(color_p1[24*i +: 24]);
      end
    end
    if (!found) begin
      case (region_p1)
        REG_SKY:  pix_c = SKY_RGB;
        REG_DIRT: pix_c = dug_p1 ? BLACK : STRATA_RGB[stratum_p1];
        default:  pix_c = BLACK;
      endcase
    end
  end

  logic vld_p2;
  rgb_t rgb_p2;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_p2 <= 1'b0;
      rgb_p2 <= BLACK;
    end else begin
      vld_p2 <= vld_p1;
      rgb_p2 <= vld_p1 ? pix_c : BLACK;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.VGA_R     = rgb_p2.r;
  assign bus.VGA_G     = rgb_p2.g;
  assign bus.VGA_B     = rgb_p2.b;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed and randomized bench for layer_compositor against a behavioural pixel/map model.
module tb_layer_compositor;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  layer_compositor_if bus ();

  layer_compositor dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  bit          model_dug [32][24];
  int          frame_m  = 0;
  logic [23:0] strata_m [4] = '{24'hFFA933, 24'hB5651D, 24'hB22222, 24'h800000};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int x, input int y, input logic [7:0] hit,
                                            input logic [191:0] col, input logic [7:0] blink);
    int s, row, cx;
    bit boff;
    boff = (((frame_m % 64) / 16) % 2) == 1;
    for (int i = 0; i < 8; i++)
      if (hit[i] && !(blink[i] && boff)) return col[24*i +: 24];
    if (x >= 512) return 24'h000000;
    if (y < 96) return 24'h0000FF;
    s   = (y - 96) / 96;
    if (s > 3) s = 3;
    row = (y - 96) / 16;
    cx  = x / 16;
    if (row < 24 && model_dug[cx][row]) return 24'h000000;
    return strata_m[s];
  endfunction

  task automatic run_pixel(input string tag, input int x, input int y, input logic [7:0] hit,
                           input logic [191:0] col, input logic [7:0] blink);
    logic [23:0] exp;
    @(negedge Clk);
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.layer_hit   = hit;
    bus.layer_color = col;
    bus.layer_blink = blink;
    bus.pix_valid   = 1'b1;
    exp = ref_pixel(x, y, hit, col, blink);
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(bus.out_valid), 32'd0);
    @(negedge Clk);
    check_eq({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_rgb"}, {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h00, exp});
  endtask

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      bus.frame_start = 1'b1;
      @(negedge Clk);
      bus.frame_start = 1'b0;
      frame_m++;
    end
  endtask

  task automatic dig(input int x, input int y);
    @(negedge Clk);
    bus.dig_we = 1'b1;
    bus.dig_x  = 5'(x);
    bus.dig_y  = 5'(y);
    @(negedge Clk);
    bus.dig_we = 1'b0;
    if (y < 24) model_dug[x][y] = 1'b1;
  endtask

  task automatic clear_model();
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 24; r++) model_dug[c][r] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [191:0] col;
    logic [7:0]   hit, blink;
    int           cnt, x, y, ldx, ldy;

    bus.pix_valid = 1'b1; bus.DrawX = 10'd10; bus.DrawY = 10'd10;
    bus.layer_hit = '0; bus.layer_color = '0; bus.layer_blink = '0;
    bus.frame_start = 1'b0; bus.dig_we = 1'b0; bus.dig_x = '0; bus.dig_y = '0;
    bus.map_clear = 1'b0;
    clear_model();

    // reset held with a valid pixel on the bus
    repeat (3) @(negedge Clk);
    check_eq("rst_vld", 32'(bus.out_valid), 32'd0);
    check_eq("rst_rgb", {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h0);
    check_eq("rst_busy", 32'(bus.map_busy), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_eq("rel_lat", 32'(bus.out_valid), 32'd0);
    @(negedge Clk);
    check_eq("rel_vld", 32'(bus.out_valid), 32'd1);
    check_eq("rel_rgb", {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'h0000FF);
    bus.pix_valid = 1'b0;
    @(negedge Clk);

    // stratum 1 then dig the covering cell
    col = '0;
    run_pixel("strat1", 40, 200, 8'h00, col, 8'h00);
    dig(2, 6);
    run_pixel("dug", 40, 200, 8'h00, col, 8'h00);

    // layer priority
    col[23:0]  = 24'hFFFFFF;
    col[71:48] = 24'h00EEFF;
    run_pixel("prio0", 100, 300, 8'b0101, col, 8'h00);
    run_pixel("prio2", 100, 300, 8'b0100, col, 8'h00);

    // blinking of layer 0 across the frame counter
    frame_pulses(16);
    run_pixel("blink_off", 100, 300, 8'b0101, col, 8'h01);
    run_pixel("blink_bg", 100, 300, 8'b0001, col, 8'h01);
    frame_pulses(16);
    run_pixel("blink_on", 100, 300, 8'b0101, col, 8'h01);
    frame_pulses(32);
    run_pixel("blink_wrap", 100, 300, 8'b0101, col, 8'h01);

    // off-field, clamped stratum below the map, out-of-range dig row dropped
    run_pixel("offfield", 600, 200, 8'h00, col, 8'h00);
    dig(7, 30);
    run_pixel("deep", 7 * 16 + 3, 520, 8'h00, col, 8'h00);
    run_pixel("oor_alias", 7 * 16 + 3, 96 + 6 * 16 + 2, 8'h00, col, 8'h00);

    // randomized pixels, digs and frame pulses
    ldx = 2; ldy = 6;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        ldx = $urandom_range(0, 31);
        ldy = $urandom_range(0, 27);
        dig(ldx, ldy);
      end
      if ($urandom_range(0, 4) == 0) frame_pulses($urandom_range(1, 9));
      if ($urandom_range(0, 1) == 1) begin
        x = ldx * 16 + $urandom_range(0, 15);
        y = 96 + ldy * 16 + $urandom_range(0, 15);
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 524);
      end
      hit   = 8'($urandom & $urandom & $urandom);
      blink = 8'($urandom);
      for (int i = 0; i < 8; i++) col[24*i +: 24] = 24'($urandom);
      run_pixel("rand", x, y, hit, col, blink);
    end

    // clear sequence with a simultaneous write and a write while busy
    dig(1, 1); dig(5, 9); dig(30, 23);
    @(negedge Clk);
    bus.map_clear = 1'b1;
    bus.dig_we = 1'b1; bus.dig_x = 5'd10; bus.dig_y = 5'd10;
    @(negedge Clk);
    bus.map_clear = 1'b0;
    bus.dig_we = 1'b0;
    check_eq("busy_start", 32'(bus.map_busy), 32'd1);
    cnt = 0;
    for (int i = 0; i < 100 && bus.map_busy; i++) begin
      cnt++;
      bus.dig_we = (i == 3);
      bus.dig_x  = 5'd12;
      bus.dig_y  = 5'd12;
      @(negedge Clk);
    end
    bus.dig_we = 1'b0;
    check_eq("busy_len", cnt, 32'd24);
    clear_model();
    col = '0;
    run_pixel("clr_a", 1 * 16 + 1, 96 + 1 * 16 + 1, 8'h00, col, 8'h00);
    run_pixel("clr_b", 5 * 16 + 1, 96 + 9 * 16 + 1, 8'h00, col, 8'h00);
    run_pixel("clr_c", 30 * 16 + 1, 96 + 23 * 16 + 1, 8'h00, col, 8'h00);
    run_pixel("clr_sim", 10 * 16 + 1, 96 + 10 * 16 + 1, 8'h00, col, 8'h00);
    run_pixel("clr_busy", 12 * 16 + 1, 96 + 12 * 16 + 1, 8'h00, col, 8'h00);

    // reset in the middle of a clear
    dig(20, 20);
    run_pixel("pre_rst", 20 * 16 + 3, 96 + 20 * 16 + 3, 8'h00, col, 8'h00);
    @(negedge Clk);
    bus.map_clear = 1'b1;
    @(negedge Clk);
    bus.map_clear = 1'b0;
    repeat (4) @(negedge Clk);
    check_eq("mid_busy", 32'(bus.map_busy), 32'd1);
    Reset_n = 1'b0;
    @(negedge Clk);
    check_eq("rst_abort", 32'(bus.map_busy), 32'd0);
    Reset_n = 1'b1;
    clear_model();
    frame_m = 0;
    run_pixel("post_rst", 20 * 16 + 3, 96 + 20 * 16 + 3, 8'h00, col, 8'h00);
    run_pixel("post_frame", 100, 300, 8'b0001, 192'hABCDEF, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
